// File: rtl/bar_pkg.sv
// rtl/bar_pkg.sv - shared constants and types for the bar stream interface
// Contents:
//   WIDTH       data width of the bar interface
//   bar_data_t  one bar data word
//   level_w()   bit width of a FIFO occupancy count for a given depth
package bar_pkg;

  localparam int WIDTH = 32;

  typedef logic [WIDTH-1:0] bar_data_t;

  // Occupancy must be able to represent DEPTH itself, hence the extra bit.
  function automatic int level_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bar.sv
// rtl/bar.sv - bar valid/ready stream interface
// Signals:
//   data   stream word (bar_data_t)
//   valid  initiator has a word on data
//   ready  target accepts the word on this edge
// Modports:
//   out  initiator side (drives data/valid, samples ready)
//   in   target side (samples data/valid, drives ready)
interface bar;
  import bar_pkg::*;

  bar_data_t data;
  logic      valid;
  logic      ready;

  modport out (output data, output valid, input ready);
  modport in  (input data, input valid, output ready);
endinterface

// File: rtl/bar_tx_fifo.sv
// rtl/bar_tx_fifo.sv - show-ahead FIFO holding storage, pointers and level
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   push        write request; taken only when not full
//   push_data   word appended at the tail
//   pop         read request; taken only when not empty
//   head        word at the FIFO head (valid when !empty)
//   level       registered occupancy, 0..DEPTH
//   full        level == DEPTH
//   empty       level == 0
module bar_tx_fifo
  import bar_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = bar_pkg::WIDTH
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = level_w(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    level_q;
  logic             do_push;
  logic             do_pop;

  // Full/empty come from the registered level only, so a pop on the same
  // edge never frees a slot for a write while full.
  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign level = level_q;
  assign head  = mem[rd_ptr];

  // Pointers are AW bits wide and DEPTH is a power of two, so plain
  // increments wrap modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      level_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until level says so.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bar_tx.sv
// rtl/bar_tx.sv - local write port feeding a bar stream initiator through a FIFO
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   wr_en       local write request
//   wr_data     local write word
//   full        FIFO holds DEPTH entries
//   level       current FIFO occupancy
//   ovf         sticky: a write was attempted while full
//   y           bar.out stream (data/valid out, ready in)
//   tx_count    completed-beat counter
// Build option: define BAR_TX_CNT_EN to implement tx_count; otherwise it is 0
// and no counter flops exist.
module bar_tx
  import bar_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = bar_pkg::WIDTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       wr_data,
  output logic                   full,
  output logic [$clog2(DEPTH):0] level,
  output logic                   ovf,
  bar.out                        y,
  output logic [31:0]            tx_count
);

  logic [WIDTH-1:0] head;
  logic             empty;
  logic             beat;

  bar_tx_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (WIDTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (wr_en),
    .push_data (wr_data),
    .pop       (beat),
    .head      (head),
    .level     (level),
    .full      (full),
    .empty     (empty)
  );

  // valid follows the registered level, so it can only fall after a pop.
  // data is forced to 0 while idle so reset leaves the bus quiet.
  assign y.valid = ~empty;
  assign y.data  = empty ? '0 : head;
  assign beat    = y.valid & y.ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (wr_en && full) begin
      ovf <= 1'b1;
    end
  end

`ifdef BAR_TX_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (beat) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign tx_count = cnt_q;
`else
  assign tx_count = '0;
`endif

endmodule

// File: tb/tb_bar_tx.sv
// tb/tb_bar_tx.sv - scoreboard bench for bar_tx
module tb_bar_tx;
  import bar_pkg::*;

`ifdef BAR_TX_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [31:0] wr_data;
  logic        full;
  logic [2:0]  level;
  logic        ovf;
  logic [31:0] tx_count;

  bar yi ();

  bar_tx #(.DEPTH(4), .WIDTH(32)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .full     (full),
    .level    (level),
    .ovf      (ovf),
    .y        (yi),
    .tx_count (tx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  bar_data_t   sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] d, input bit exp_acc);
    wr_en   = 1'b1;
    wr_data = d;
    if (exp_acc) sb.push_back(d);
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  // Monitor: a beat completes on the next rising edge whenever valid and
  // ready are both high at the falling edge.
  always @(negedge clk) begin
    if (rst_n && yi.valid && yi.ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        $display("FAIL beat_unexpected: got beat data 0x%0h expected no beat", yi.data);
      end else begin
        bar_data_t e;
        e = sb.pop_front();
        check("beat_data", yi.data, e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n    = 1'b1;
    wr_en    = 1'b0;
    wr_data  = '0;
    yi.ready = 1'b0;
    #1 rst_n = 1'b0;
    #10;
    check("rst_valid", {31'b0, yi.valid}, 32'd0);
    check("rst_level", {29'b0, level}, 32'd0);
    check("rst_full", {31'b0, full}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_data", yi.data, 32'd0);
    check("rst_cnt", tx_count, 32'd0);
    #1 rst_n = 1'b1;
    step();
    check("release_valid", {31'b0, yi.valid}, 32'd0);

    // Basic order with ready held high
    yi.ready = 1'b1;
    wr(32'h11, 1'b1);
    check("latency_valid", {31'b0, yi.valid}, 32'd1);
    check("latency_data", yi.data, 32'h11);
    wr(32'h22, 1'b1);
    check("stream_level1", {29'b0, level}, 32'd1);
    wr(32'h33, 1'b1);
    check("stream_level2", {29'b0, level}, 32'd1);
    step();
    check("stream_drained", {29'b0, level}, 32'd0);
    check("stream_idle", {31'b0, yi.valid}, 32'd0);

    // Backpressure hold
    yi.ready = 1'b0;
    wr(32'hAAAA5555, 1'b1);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {31'b0, yi.valid}, 32'd1);
      check("hold_data", yi.data, 32'hAAAA5555);
      if (i < 4) step();
    end
    yi.ready = 1'b1;
    step();
    yi.ready = 1'b0;
    check("hold_done", {29'b0, level}, 32'd0);

    // Full and overflow
    wr(32'h1, 1'b1);
    wr(32'h2, 1'b1);
    wr(32'h3, 1'b1);
    check("fill3_full", {31'b0, full}, 32'd0);
    wr(32'h4, 1'b1);
    check("fill4_full", {31'b0, full}, 32'd1);
    check("fill4_level", {29'b0, level}, 32'd4);
    check("fill4_ovf", {31'b0, ovf}, 32'd0);
    wr(32'h5, 1'b0);
    check("ovf_set", {31'b0, ovf}, 32'd1);
    check("ovf_level", {29'b0, level}, 32'd4);
    check("ovf_head", yi.data, 32'h1);
    yi.ready = 1'b1;
    repeat (4) step();
    yi.ready = 1'b0;
    check("ovf_drained", {29'b0, level}, 32'd0);
    check("ovf_sticky", {31'b0, ovf}, 32'd1);

    // Simultaneous write and beat
    wr(32'h100, 1'b1);
    wr(32'h200, 1'b1);
    check("simul_pre", {29'b0, level}, 32'd2);
    yi.ready = 1'b1;
    wr(32'h300, 1'b1);
    check("simul_level", {29'b0, level}, 32'd2);
    check("simul_head", yi.data, 32'h200);
    step();
    step();
    check("simul_drained", {29'b0, level}, 32'd0);
    yi.ready = 1'b0;

    // Reset mid-operation discards contents
    wr(32'hA1, 1'b0);
    wr(32'hA2, 1'b0);
    wr(32'hA3, 1'b0);
    check("mid_level", {29'b0, level}, 32'd3);
    check("mid_valid", {31'b0, yi.valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", {31'b0, yi.valid}, 32'd0);
    check("arst_level", {29'b0, level}, 32'd0);
    check("arst_ovf", {31'b0, ovf}, 32'd0);
    check("arst_data", yi.data, 32'd0);
    check("arst_full", {31'b0, full}, 32'd0);
    yi.ready = 1'b1;
    step();
    check("in_rst_valid", {31'b0, yi.valid}, 32'd0);
    #3 rst_n = 1'b1;
    step();
    step();
    check("post_rst_valid", {31'b0, yi.valid}, 32'd0);
    check("post_rst_level", {29'b0, level}, 32'd0);
    wr(32'h5A, 1'b1);
    check("resume_valid", {31'b0, yi.valid}, 32'd1);
    step();
    check("resume_level", {29'b0, level}, 32'd0);
    check("cnt_after_resume", tx_count, CNT_ON ? 32'd1 : 32'd0);

    // Beat counter wrap
`ifdef BAR_TX_CNT_EN
    force dut.cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.cnt_q;
`endif
    wr(32'hC1, 1'b1);
    check("cnt_0", tx_count, CNT_ON ? 32'hFFFFFFFE : 32'd0);
    wr(32'hC2, 1'b1);
    check("cnt_1", tx_count, CNT_ON ? 32'hFFFFFFFF : 32'd0);
    wr(32'hC3, 1'b1);
    check("cnt_2", tx_count, 32'd0);
    step();
    check("cnt_3", tx_count, CNT_ON ? 32'd1 : 32'd0);
    yi.ready = 1'b0;

    repeat (3) step();
    check("sb_empty", sb.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bar_tx.md
BAR_TX -- requirements
Module: bar_tx

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entries; power of two, at least 2.
REQ-002 SHALL have parameter WIDTH, default 32, data width; equals the bar interface data width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port wr_en  input  1  local write request.
REQ-006 SHALL have port wr_data  input  WIDTH  local write word.
REQ-007 SHALL have port full  output  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port level  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-009 SHALL have port ovf  output  1  sticky overflow flag.
REQ-010 SHALL have port y  bar.out modport  data (WIDTH) out, valid out, ready in; this block is the stream initiator.
REQ-011 SHALL have port tx_count  output  32  accepted-beat counter (see Configuration).

Function
REQ-012 SHALL accept a write on a clock edge when wr_en=1 and full=0; the word is appended at the FIFO tail.
REQ-013 SHALL ignore a write when wr_en=1 and full=1, and SHALL set ovf=1 on that edge; FIFO contents are unchanged.
REQ-014 SHALL drive y.valid=1 exactly when level>0, with y.data equal to the FIFO head (show-ahead).
REQ-015 SHALL give one-cycle first-word latency: a write into an empty FIFO makes y.valid=1 on the following cycle.
REQ-016 SHALL complete a beat on an edge where y.valid=1 and y.ready=1, popping the head.
REQ-017 SHALL hold y.data stable while y.valid=1 and y.ready=0, and SHALL never deassert y.valid without a completed beat.
REQ-018 SHALL, on a simultaneous accepted write and completed beat, leave level unchanged and keep order.
REQ-019 SHALL compute full from the registered level; when full, a simultaneous pop does not make the same-edge write acceptable.
REQ-020 SHALL wrap read and write pointers modulo DEPTH, using a registered level counter for full and empty.
REQ-021 SHALL ignore y.ready while y.valid=0.

Reset
REQ-022 SHALL, on rst_n=0, immediately clear level, pointers, ovf and tx_count, and drive y.valid=0, full=0, y.data=0.
REQ-023 SHALL discard all FIFO contents on a reset asserted mid-transfer; no beat completes while rst_n=0.
REQ-024 SHALL release reset on the first rising clk with rst_n=1, with no spurious valid on that edge.

Configuration
REQ-025 SHALL, with macro BAR_TX_CNT_EN defined, increment tx_count by 1 per completed beat, wrapping from 0xFFFFFFFF to 0.
REQ-026 SHALL, without BAR_TX_CNT_EN, tie tx_count to 0 and SHALL NOT instantiate counter flops; all other behaviour is identical.

Structure
REQ-027 SHALL take the bar interface definition and the WIDTH constant from shared package bar_pkg, along with typedef bar_data_t (logic [WIDTH-1:0]).
REQ-028 SHALL place storage, pointers and level in sub-module bar_tx_fifo; bar_tx holds the handshake glue, ovf and tx_count.

Verification
REQ-029 Basic order: write 0x11, 0x22, 0x33 with ready=1 -> y.data sequence 0x11, 0x22, 0x33 on three consecutive beats; first beat valid one cycle after the first write.
REQ-030 Backpressure: write 0xAAAA5555 with ready=0 for 5 cycles -> valid=1 and data=0xAAAA5555 held stable for 5 cycles; beat completes on the edge where ready rises.
REQ-031 Full/overflow: 5 writes (0x1..0x5) with ready=0, DEPTH=4 -> full=1 after the 4th, 0x5 dropped, ovf=1; draining yields 0x1..0x4 only.
REQ-032 Simultaneous: level=2 with write and beat on the same edge -> level stays 2, order preserved.
REQ-033 Reset mid-operation: level=3 and valid=1, pulse rst_n low between edges -> valid=0, level=0, ovf=0 immediately; no beat after release until a new write.
REQ-034 Counter (BAR_TX_CNT_EN): preload tx_count=0xFFFFFFFE via force, complete 3 beats -> tx_count 0xFFFFFFFF, 0, 1; without the macro tx_count stays 0.
